// File: rtl/calc_session_ctrl.sv
// Session sequencer for the calculator CPU: snapshots N_OPS signed operands, streams them
// into the CPU one per cycle, runs the CPU until done or timeout, and latches the result.
module calc_session_ctrl #(
  parameter int DATA_W      = 30,
  parameter int N_OPS       = 2,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int CNT_W      = $clog2(TIMEOUT_CYC) + 1,
  localparam int IW         = $clog2(N_OPS) + 1
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      go,
  input  logic                      clear,
  input  logic [N_OPS-1:0]          op_sign,
  input  logic [N_OPS*DATA_W-1:0]   op_mag,
  output logic                      cpu_rst,
  output logic                      cpu_wr_en,
  output logic [IW-1:0]             cpu_wr_idx,
  output logic                      cpu_wr_sign,
  output logic [DATA_W-1:0]         cpu_wr_data,
  input  logic                      cpu_done,
  input  logic                      cpu_res_sign,
  input  logic [DATA_W-1:0]         cpu_res_data,
  output logic                      busy,
  output logic                      res_valid,
  output logic                      res_sign,
  output logic [DATA_W-1:0]         res_data,
  output logic [CNT_W-1:0]          run_cycles,
  output logic                      err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

  state_t                    state_q, state_d;
  logic                      go_q;
  logic                      go_rise;
  logic [IW-1:0]             idx_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [N_OPS-1:0]          snap_sign;
  logic [N_OPS*DATA_W-1:0]   snap_mag;
  logic                      cur_sign;
  logic [DATA_W-1:0]         cur_mag;
  logic                      start, load_last, done_hit, tmo_hit;
  logic                      in_load, in_run;

  assign go_rise = go & ~go_q;
  assign in_load = (state_q == S_LOAD);
  assign in_run  = (state_q == S_RUN);

  // Priority: clear > cpu_done > timeout > go_rise
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    load_last = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (go_rise) begin
            start   = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          if (idx_q == IW'(N_OPS - 1)) begin
            load_last = 1'b1;
            state_d   = S_RUN;
          end
        end
        S_RUN: begin
          if (cpu_done) begin
            done_hit = 1'b1;
            state_d  = S_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            tmo_hit = 1'b1;
            state_d = S_ERR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_sign = 1'b0;
    cur_mag  = '0;
    for (int unsigned i = 0; i < N_OPS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_sign = snap_sign[i];
        cur_mag  = snap_mag[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Strobes are registered from the current state, so they trail the state by one edge;
  // clear overrides that lag so the CPU is held in reset on the same edge the FSM aborts.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      go_q        <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      snap_sign   <= '0;
      snap_mag    <= '0;
      cpu_rst     <= 1'b1;
      cpu_wr_en   <= 1'b0;
      cpu_wr_idx  <= '0;
      cpu_wr_sign <= 1'b0;
      cpu_wr_data <= '0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_sign    <= 1'b0;
      res_data    <= '0;
      run_cycles  <= '0;
      err_timeout <= 1'b0;
    end else begin
      go_q        <= go;
      cpu_rst     <= clear | ~in_run;
      busy        <= ~clear & (in_load | in_run);
      cpu_wr_en   <= ~clear & in_load;
      cpu_wr_idx  <= (~clear & in_load) ? idx_q : '0;
      cpu_wr_sign <= ~clear & in_load & cur_sign;
      cpu_wr_data <= (~clear & in_load) ? cur_mag : '0;

      if (start) begin
        snap_sign   <= op_sign;
        snap_mag    <= op_mag;
        idx_q       <= '0;
        res_valid   <= 1'b0;
        err_timeout <= 1'b0;
        run_cycles  <= '0;
      end

      if (in_load && !clear) begin
        idx_q <= idx_q + 1'b1;
        if (load_last) cnt_q <= '0;
      end

      if (in_run && !clear) cnt_q <= cnt_q + 1'b1;

      if (done_hit) begin
        res_valid  <= 1'b1;
        res_sign   <= cpu_res_sign & (cpu_res_data != '0);
        res_data   <= cpu_res_data;
        run_cycles <= cnt_q;
      end

      if (tmo_hit) begin
        err_timeout <= 1'b1;
        run_cycles  <= cnt_q;
      end

      if (clear && (in_load || in_run)) begin
        res_valid   <= 1'b0;
        err_timeout <= 1'b0;
      end
    end
  end

endmodule
